// File: rtl/dram_sched_buffer.sv
// rtl/dram_sched_buffer.sv - request queue and refresh timer ahead of the DRAM command generator
module dram_sched_buffer #(
    parameter int DEPTH = 8,
    parameter int tREFI = 6240,
    parameter int tRFC  = 208
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [2:0]  Ra0,
    output logic [2:0]  Ra1,
    output logic [1:0]  BG0,
    output logic [1:0]  BG1,
    output logic [1:0]  BA0,
    output logic [1:0]  BA1,
    output logic [17:0] R0,
    output logic [17:0] R1,
    output logic [13:0] COL0,
    output logic [13:0] COL1,
    output logic        dREN_curr,
    output logic        dWEN_curr,
    output logic        dREN_ftrt,
    output logic        dWEN_ftrt,
    output logic [31:0] write_data,
    output logic        REFRESH,
    input  logic        request_done,
    input  logic [31:0] data_callback,
    output logic        rsp_valid,
    output logic        rsp_wen,
    output logic [31:0] rsp_rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = $clog2(tREFI + 1);
    localparam int FW = $clog2(tRFC + 1);

    // Queue storage holds already-decoded address fields so the outputs are a plain read.
    logic        r_mem_wen   [DEPTH];
    logic [2:0]  r_mem_ra    [DEPTH];
    logic [1:0]  r_mem_bg    [DEPTH];
    logic [1:0]  r_mem_ba    [DEPTH];
    logic [17:0] r_mem_row   [DEPTH];
    logic [13:0] r_mem_col   [DEPTH];
    logic [31:0] r_mem_wdata [DEPTH];

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;

    logic [RW-1:0] r_ref_cnt;
    logic [FW-1:0] r_rfc_cnt;
    logic          r_pending;
    logic          r_refresh;

    logic          r_rsp_valid;
    logic          r_rsp_wen;
    logic [31:0]   r_rsp_rdata;

    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_curr_vld;
    logic          w_ftrt_vld;
    logic [AW-1:0] w_head1;
    logic          w_expire;
    logic          w_ref_start;
    logic          w_unused;

    logic [2:0]    w_dec_ra;
    logic [1:0]    w_dec_bg;
    logic [1:0]    w_dec_ba;
    logic [17:0]   w_dec_row;
    logic [13:0]   w_dec_col;

    // Byte offset within a 32-bit word carries no DRAM addressing information.
    assign w_unused  = ^req_addr[1:0];

    assign w_dec_col = {4'b0, req_addr[11:2]};
    assign w_dec_ba  = req_addr[13:12];
    assign w_dec_bg  = req_addr[15:14];
    assign w_dec_row = {3'b0, req_addr[30:16]};
    assign w_dec_ra  = {2'b0, req_addr[31]};

    // Readiness comes from the registered count only, so a same-cycle pop never frees a slot.
    assign w_full     = (r_count == (AW+1)'(DEPTH));
    assign req_ready  = ~w_full;
    assign w_push     = req_valid & ~w_full;
    assign w_curr_vld = (r_count != '0);
    assign w_ftrt_vld = (r_count > (AW+1)'(1));
    assign w_head1    = r_head + AW'(1);

    // Head entry; its command flags are suppressed while a refresh window is open.
    assign Ra0        = w_curr_vld ? r_mem_ra[r_head]    : '0;
    assign BG0        = w_curr_vld ? r_mem_bg[r_head]    : '0;
    assign BA0        = w_curr_vld ? r_mem_ba[r_head]    : '0;
    assign R0         = w_curr_vld ? r_mem_row[r_head]   : '0;
    assign COL0       = w_curr_vld ? r_mem_col[r_head]   : '0;
    assign write_data = w_curr_vld ? r_mem_wdata[r_head] : '0;
    assign dREN_curr  = w_curr_vld & ~r_refresh & ~r_mem_wen[r_head];
    assign dWEN_curr  = w_curr_vld & ~r_refresh &  r_mem_wen[r_head];

    // Second entry stays visible during refresh so the generator can plan ahead.
    assign Ra1        = w_ftrt_vld ? r_mem_ra[w_head1]  : '0;
    assign BG1        = w_ftrt_vld ? r_mem_bg[w_head1]  : '0;
    assign BA1        = w_ftrt_vld ? r_mem_ba[w_head1]  : '0;
    assign R1         = w_ftrt_vld ? r_mem_row[w_head1] : '0;
    assign COL1       = w_ftrt_vld ? r_mem_col[w_head1] : '0;
    assign dREN_ftrt  = w_ftrt_vld & ~r_mem_wen[w_head1];
    assign dWEN_ftrt  = w_ftrt_vld &  r_mem_wen[w_head1];

    // Completion is honoured only when the generator could legitimately see a command.
    assign w_pop = request_done & (dREN_curr | dWEN_curr);

    assign w_expire    = (r_ref_cnt == RW'(tREFI - 1));
    assign w_ref_start = r_pending & ~r_refresh & (~w_curr_vld | request_done);

    assign REFRESH   = r_refresh;
    assign rsp_valid = r_rsp_valid;
    assign rsp_wen   = r_rsp_wen;
    assign rsp_rdata = r_rsp_rdata;

    // Entry storage; contents need no reset because the count gates every output.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem_wen[r_tail]   <= req_wen;
            r_mem_ra[r_tail]    <= w_dec_ra;
            r_mem_bg[r_tail]    <= w_dec_bg;
            r_mem_ba[r_tail]    <= w_dec_ba;
            r_mem_row[r_tail]   <= w_dec_row;
            r_mem_col[r_tail]   <= w_dec_col;
            r_mem_wdata[r_tail] <= req_wdata;
        end
    end

    // Head/tail pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + AW'(1);
            if (w_pop)  r_head <= r_head + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // One-cycle completion pulse back to the requester; write completions return zero data.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rsp_valid <= 1'b0;
            r_rsp_wen   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_pop;
            r_rsp_wen   <= w_pop & dWEN_curr;
            r_rsp_rdata <= (w_pop & dREN_curr) ? data_callback : '0;
        end
    end

    // Refresh interval timer, single-bit pending flag and fixed-length refresh window.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_ref_cnt <= '0;
            r_rfc_cnt <= '0;
            r_pending <= 1'b0;
            r_refresh <= 1'b0;
        end else begin
            r_ref_cnt <= w_expire ? '0 : r_ref_cnt + RW'(1);

            if (w_expire)         r_pending <= 1'b1;
            else if (w_ref_start) r_pending <= 1'b0;

            if (r_refresh) begin
                if (r_rfc_cnt == '0) r_refresh <= 1'b0;
                else                 r_rfc_cnt <= r_rfc_cnt - FW'(1);
            end else if (w_ref_start) begin
                r_refresh <= 1'b1;
                r_rfc_cnt <= FW'(tRFC - 1);
            end
        end
    end

endmodule

// File: tb/tb_dram_sched_buffer.sv
// tb/tb_dram_sched_buffer.sv - self-checking bench for dram_sched_buffer
module tb_dram_sched_buffer;

    localparam int DEPTH = 8;
    localparam int TREFI = 6240;
    localparam int TRFC  = 208;

    logic        CLK;
    logic        nRST;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  Ra0, Ra1;
    logic [1:0]  BG0, BG1, BA0, BA1;
    logic [17:0] R0, R1;
    logic [13:0] COL0, COL1;
    logic        dREN_curr, dWEN_curr, dREN_ftrt, dWEN_ftrt;
    logic [31:0] write_data;
    logic        REFRESH;
    logic        request_done;
    logic [31:0] data_callback;
    logic        rsp_valid;
    logic        rsp_wen;
    logic [31:0] rsp_rdata;

    dram_sched_buffer #(.DEPTH(DEPTH), .tREFI(TREFI), .tRFC(TRFC)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .Ra0(Ra0), .Ra1(Ra1), .BG0(BG0), .BG1(BG1), .BA0(BA0), .BA1(BA1),
        .R0(R0), .R1(R1), .COL0(COL0), .COL1(COL1),
        .dREN_curr(dREN_curr), .dWEN_curr(dWEN_curr),
        .dREN_ftrt(dREN_ftrt), .dWEN_ftrt(dWEN_ftrt),
        .write_data(write_data), .REFRESH(REFRESH),
        .request_done(request_done), .data_callback(data_callback),
        .rsp_valid(rsp_valid), .rsp_wen(rsp_wen), .rsp_rdata(rsp_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit        wen;
        bit [31:0] addr;
        bit [31:0] wdata;
    } ent_t;

    int   errors = 0;
    int   checks = 0;
    ent_t m_q[$];
    bit   m_win;
    bit   m_pend;
    int   m_left;
    int   m_cyc;
    bit          e_rsp_valid;
    bit          e_rsp_wen;
    bit [31:0]   e_rsp_rdata;

    logic [72:0] act_curr;
    logic [40:0] act_ftrt;
    logic [33:0] act_rsp;
    assign act_curr = {Ra0, BG0, BA0, R0, COL0, dREN_curr, dWEN_curr, write_data};
    assign act_ftrt = {Ra1, BG1, BA1, R1, COL1, dREN_ftrt, dWEN_ftrt};
    assign act_rsp  = {rsp_valid, rsp_wen, rsp_rdata};

    function automatic logic [40:0] dec(input logic [31:0] a, input logic wen, input logic show);
        logic [2:0]  ra;
        logic [1:0]  bg;
        logic [1:0]  ba;
        logic [17:0] row;
        logic [13:0] col;
        ra  = 3'(a / 32'h8000_0000);
        row = 18'((a / 65536) % 32768);
        bg  = 2'((a / 16384) % 4);
        ba  = 2'((a / 4096) % 4);
        col = 14'((a / 4) % 1024);
        return {ra, bg, ba, row, col, show & ~wen, show & wen};
    endfunction

    function automatic logic [72:0] exp_curr();
        if (m_q.size() == 0) return '0;
        return {dec(m_q[0].addr, m_q[0].wen, !m_win), m_q[0].wdata};
    endfunction

    function automatic logic [40:0] exp_ftrt();
        if (m_q.size() < 2) return '0;
        return dec(m_q[1].addr, m_q[1].wen, 1'b1);
    endfunction

    function automatic logic [33:0] exp_rsp();
        return {e_rsp_valid, e_rsp_wen, e_rsp_rdata};
    endfunction

    task automatic step(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic dn, input logic [31:0] cb);
        bit   acc;
        bit   pop;
        bit   start;
        ent_t e;
        req_valid = v; req_wen = w; req_addr = a; req_wdata = d;
        request_done = dn; data_callback = cb;
        acc   = v && (m_q.size() < DEPTH);
        pop   = dn && (m_q.size() > 0) && !m_win;
        start = m_pend && !m_win && ((m_q.size() == 0) || dn);
        e_rsp_valid = pop;
        e_rsp_wen   = 1'b0;
        e_rsp_rdata = '0;
        if (pop) begin
            e_rsp_wen   = m_q[0].wen;
            e_rsp_rdata = m_q[0].wen ? 32'h0 : cb;
        end
        @(posedge CLK);
        m_cyc++;
        if (pop) void'(m_q.pop_front());
        if (acc) begin
            e.wen = w; e.addr = a; e.wdata = d;
            m_q.push_back(e);
        end
        if (m_win) begin
            m_left--;
            if (m_left == 0) m_win = 1'b0;
        end else if (start) begin
            m_win  = 1'b1;
            m_left = TRFC;
        end
        if (m_cyc % TREFI == 0) m_pend = 1'b1;
        else if (start)         m_pend = 1'b0;
        @(negedge CLK);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0;
        request_done = 0; data_callback = 0;
        @(negedge CLK);
        @(negedge CLK);
        m_q.delete();
        m_win = 0; m_pend = 0; m_left = 0; m_cyc = 0;
        e_rsp_valid = 0; e_rsp_wen = 0; e_rsp_rdata = 0;
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        req_valid = 0; request_done = 0;
        @(negedge CLK);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        checks++; if (REFRESH !== 1'b0) begin errors++; $display("FAIL reset_refresh got=%b exp=0", REFRESH); end
        checks++; if (act_curr !== 73'h0) begin errors++; $display("FAIL reset_curr got=%h exp=0", act_curr); end
        checks++; if (act_ftrt !== 41'h0) begin errors++; $display("FAIL reset_ftrt got=%h exp=0", act_ftrt); end
        checks++; if (act_rsp !== 34'h0) begin errors++; $display("FAIL reset_rsp got=%h exp=0", act_rsp); end
        do_reset();
    endtask

    task automatic test_decode();
        do_reset();
        step(1'b1, 1'b0, 32'h0001_F3A4, 32'h1111_2222, 1'b0, 32'h0);
        checks++; if (dREN_curr !== 1'b1) begin errors++; $display("FAIL dec_ren got=%b exp=1", dREN_curr); end
        checks++; if (R0 !== 18'h1) begin errors++; $display("FAIL dec_R0 got=%h exp=1", R0); end
        checks++; if (BG0 !== 2'd3) begin errors++; $display("FAIL dec_BG0 got=%h exp=3", BG0); end
        checks++; if (BA0 !== 2'd3) begin errors++; $display("FAIL dec_BA0 got=%h exp=3", BA0); end
        checks++; if (COL0 !== 14'h0E9) begin errors++; $display("FAIL dec_COL0 got=%h exp=0e9", COL0); end
        checks++; if (Ra0 !== 3'd0) begin errors++; $display("FAIL dec_Ra0 got=%h exp=0", Ra0); end
        checks++; if ({dREN_ftrt, dWEN_ftrt} !== 2'b00) begin errors++; $display("FAIL dec_ftrt_flags got=%b exp=00", {dREN_ftrt, dWEN_ftrt}); end
        step(1'b1, 1'b1, 32'h8001_F3A7, 32'h3333_4444, 1'b0, 32'h0);
        checks++; if (Ra1 !== 3'd1) begin errors++; $display("FAIL dec_Ra1 got=%h exp=1", Ra1); end
        checks++; if (act_ftrt !== exp_ftrt()) begin errors++; $display("FAIL dec_ftrt got=%h exp=%h", act_ftrt, exp_ftrt()); end
    endtask

    task automatic test_write_read();
        logic [31:0] a_addr, a_data, b_addr;
        do_reset();
        a_addr = $urandom; a_data = $urandom; b_addr = $urandom;
        step(1'b1, 1'b1, a_addr, a_data, 1'b0, 32'h0);
        step(1'b1, 1'b0, b_addr, 32'h0, 1'b0, 32'h0);
        checks++; if (dWEN_curr !== 1'b1) begin errors++; $display("FAIL wr_wen_curr got=%b exp=1", dWEN_curr); end
        checks++; if (write_data !== a_data) begin errors++; $display("FAIL wr_data got=%h exp=%h", write_data, a_data); end
        checks++; if (dREN_ftrt !== 1'b1) begin errors++; $display("FAIL wr_ren_ftrt got=%b exp=1", dREN_ftrt); end
        checks++; if (act_curr !== exp_curr()) begin errors++; $display("FAIL wr_curr got=%h exp=%h", act_curr, exp_curr()); end
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h5555_AAAA);
        checks++; if (act_curr !== exp_curr()) begin errors++; $display("FAIL wr_curr_after got=%h exp=%h", act_curr, exp_curr()); end
        checks++; if (dREN_curr !== 1'b1) begin errors++; $display("FAIL wr_ren_after got=%b exp=1", dREN_curr); end
        checks++; if (act_rsp !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL wr_rsp got=%h exp=%h", act_rsp, {1'b1, 1'b1, 32'h0}); end
    endtask

    task automatic test_full();
        int pops;
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'($urandom), $urandom, $urandom, 1'b0, 32'h0);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", req_ready); end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0);
        checks++; if (act_curr !== exp_curr()) begin errors++; $display("FAIL full_held_curr got=%h exp=%h", act_curr, exp_curr()); end
        step(1'b1, 1'b1, 32'h7777_0000, 32'hEEEE_0000, 1'b1, 32'h0);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL full_pushpop_ready got=%b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL full_pushpop_rsp got=%b exp=1", rsp_valid); end
        pops = 1;
        for (int i = 0; i < DEPTH + 3; i++) begin
            step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, $urandom);
            if (rsp_valid === 1'b1) pops++;
            checks++; if (act_curr !== exp_curr()) begin errors++; $display("FAIL full_drain_curr got=%h exp=%h", act_curr, exp_curr()); end
        end
        checks++; if (pops != DEPTH) begin errors++; $display("FAIL full_pop_count got=%0d exp=%0d", pops, DEPTH); end
    endtask

    task automatic test_read_data();
        do_reset();
        step(1'b1, 1'b0, $urandom, $urandom, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        checks++; if (act_rsp !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin errors++; $display("FAIL rd_rsp got=%h exp=%h", act_rsp, {1'b1, 1'b0, 32'hDEAD_BEEF}); end
        idle();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_rsp_pulse got=%b exp=0", rsp_valid); end
        checks++; if (act_curr !== 73'h0) begin errors++; $display("FAIL rd_empty got=%h exp=0", act_curr); end
    endtask

    task automatic test_random();
        int vp;
        int dp;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            vp = (i < 200) ? 70 : 30;
            dp = (i < 200) ? 30 : 70;
            checks++; if (req_ready !== (m_q.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready got=%b exp=%b", req_ready, m_q.size() < DEPTH); end
            step(1'($urandom_range(99) < vp), 1'($urandom), $urandom, $urandom,
                 1'($urandom_range(99) < dp), $urandom);
            checks++; if (act_curr !== exp_curr()) begin errors++; $display("FAIL rnd_curr cyc=%0d got=%h exp=%h", i, act_curr, exp_curr()); end
            checks++; if (act_ftrt !== exp_ftrt()) begin errors++; $display("FAIL rnd_ftrt cyc=%0d got=%h exp=%h", i, act_ftrt, exp_ftrt()); end
            checks++; if (act_rsp !== exp_rsp()) begin errors++; $display("FAIL rnd_rsp cyc=%0d got=%h exp=%h", i, act_rsp, exp_rsp()); end
        end
    endtask

    task automatic test_refresh_idle();
        int rise;
        int hi;
        int bad_ren;
        int bad_rsp;
        do_reset();
        rise = 0;
        for (int i = 1; i <= TREFI + 20; i++) begin
            idle();
            if (REFRESH === 1'b1) begin rise = i; break; end
        end
        checks++; if (rise != TREFI + 1) begin errors++; $display("FAIL ref_rise_cycle got=%0d exp=%0d", rise, TREFI + 1); end
        hi = 1; bad_ren = 0; bad_rsp = 0;
        for (int i = 1; i <= TRFC + 20; i++) begin
            step(1'(i == 5), 1'b0, 32'h0123_4568, 32'h0, 1'(i == 10), 32'h1234_5678);
            if (REFRESH !== 1'b1) break;
            hi++;
            if (i >= 5 && dREN_curr !== 1'b0) bad_ren++;
            if (rsp_valid !== 1'b0) bad_rsp++;
        end
        checks++; if (hi != TRFC) begin errors++; $display("FAIL ref_window_len got=%0d exp=%0d", hi, TRFC); end
        checks++; if (bad_ren != 0) begin errors++; $display("FAIL ref_ren_masked got=%0d exp=0", bad_ren); end
        checks++; if (bad_rsp != 0) begin errors++; $display("FAIL ref_no_pop got=%0d exp=0", bad_rsp); end
        checks++; if (dREN_curr !== 1'b1) begin errors++; $display("FAIL ref_ren_after got=%b exp=1", dREN_curr); end
        checks++; if (act_curr !== exp_curr()) begin errors++; $display("FAIL ref_curr_after got=%h exp=%h", act_curr, exp_curr()); end
    endtask

    task automatic test_refresh_busy();
        int saw;
        do_reset();
        step(1'b1, 1'b0, $urandom, 32'h0, 1'b0, 32'h0);
        saw = 0;
        for (int i = 0; i < TREFI + 5; i++) begin
            idle();
            if (REFRESH !== 1'b0) saw++;
        end
        checks++; if (saw != 0) begin errors++; $display("FAIL busy_refresh_early got=%0d exp=0", saw); end
        checks++; if (dREN_curr !== 1'b1) begin errors++; $display("FAIL busy_head_held got=%b exp=1", dREN_curr); end
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hCAFE_F00D);
        checks++; if (REFRESH !== 1'b1) begin errors++; $display("FAIL busy_refresh_start got=%b exp=1", REFRESH); end
        checks++; if (act_rsp !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin errors++; $display("FAIL busy_rsp got=%h exp=%h", act_rsp, {1'b1, 1'b0, 32'hCAFE_F00D}); end
        step(1'b1, 1'b1, $urandom, $urandom, 1'b0, 32'h0);
        checks++; if (act_curr !== exp_curr()) begin errors++; $display("FAIL busy_window_curr got=%h exp=%h", act_curr, exp_curr()); end
        checks++; if (dWEN_curr !== 1'b0) begin errors++; $display("FAIL busy_wen_masked got=%b exp=0", dWEN_curr); end
        for (int i = 0; i < 5; i++) idle();
        #2 nRST = 1'b0;
        #1;
        checks++; if (REFRESH !== 1'b0) begin errors++; $display("FAIL busy_rst_refresh got=%b exp=0", REFRESH); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL busy_rst_ready got=%b exp=1", req_ready); end
        checks++; if (act_curr !== 73'h0) begin errors++; $display("FAIL busy_rst_curr got=%h exp=0", act_curr); end
        do_reset();
        idle();
        checks++; if (act_curr !== 73'h0) begin errors++; $display("FAIL busy_rst_empty got=%h exp=0", act_curr); end
    endtask

    initial begin
        nRST = 1'b0;
        req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0;
        request_done = 0; data_callback = 0;
        test_reset();
        test_decode();
        test_write_read();
        test_full();
        test_read_data();
        test_random();
        test_refresh_idle();
        test_refresh_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
